// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
  } lsu_ctl_t;

  // Byte-lane strobes for one beat; the access footprint spans two beats of lanes.
  function automatic logic [7:0] lsu_strb(input logic [2:0] off, input logic [1:0] size,
                                          input logic beat, input logic nb8);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    if (nb8) return beat ? m[15:8] : m[7:0];
    else     return {4'b0000, (beat ? m[7:4] : m[3:0])};
  endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Request, memory-beat and response signals of the load/store alignment unit.
interface lsu_align_unit_if #(parameter int unsigned XLEN = 64);
  localparam int unsigned NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [NB-1:0]   mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store rotate/strobes and load gather/extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned XLEN = 64,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned OFFW = $clog2(NB),
  localparam int unsigned IW   = $clog2(XLEN)
) (
  input  logic [OFFW-1:0] off,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rd_lo,
  input  logic [XLEN-1:0] rd_hi,
  output logic [XLEN-1:0] wdata_rot_c,
  output logic [NB-1:0]   strb0_c,
  output logic [NB-1:0]   strb1_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [31:0]       shamt;
  logic [2*XLEN-1:0] cat;
  logic [XLEN-1:0]   val;
  logic [XLEN-1:0]   mask;
  logic [7:0]        nbits;
  logic [IW-1:0]     sidx;
  logic              sgn;

  assign strb0_c = NB'(lsu_strb(3'(off), size, 1'b0, NB == 8));
  assign strb1_c = NB'(lsu_strb(3'(off), size, 1'b1, NB == 8));

  always_comb begin
    shamt       = 32'(off) << 3;
    wdata_rot_c = (wdata << shamt) | (wdata >> (XLEN - shamt));
    // Beat 1 bytes sit above beat 0 bytes, so one right shift gathers both.
    cat         = {rd_hi, rd_lo} >> shamt;
    val         = cat[XLEN-1:0];
    nbits       = 8'd8 << size;
    if (nbits > 8'(XLEN)) nbits = 8'(XLEN);
    mask        = ~({XLEN{1'b1}} << nbits);
    sidx        = IW'(nbits - 8'd1);
    sgn         = ~uns & val[sidx];
    rdata_c     = (val & mask) | ({XLEN{sgn}} & ~mask);
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Multi-cycle load/store unit: request registers, beat FSM and read capture.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ALIGN_SPLIT = 1
) (
  input logic            clk,
  input logic            rst,
  lsu_align_unit_if.slave bus
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  lsu_ctl_t        ctl_q, ctl_d;
  logic [OFFW-1:0] off_q, off_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] cap_q, cap_d;
  logic            req_ready_q, mem_valid_q;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [NB-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [OFFW-1:0] req_off_c, sel_off_c;
  logic [1:0]      sel_size_c;
  logic [4:0]      span_c;
  logic            split_c, mis_c, err_c;
  logic [XLEN-1:0] base_c, rd_lo_c, wrot_c, rfmt_c;
  logic [NB-1:0]   strb0_c, strb1_c;

  // Request decode on the live bus: alignment, split and error classification.
  assign req_off_c = bus.req_addr[OFFW-1:0];
  assign base_c    = {bus.req_addr[XLEN-1:OFFW], OFFW'(0)};
  assign span_c    = 5'(req_off_c) + (5'd1 << bus.req_size);
  assign split_c   = (ALIGN_SPLIT != 0) && (span_c > 5'(NB));
  assign mis_c     = ((bus.req_size == SZ_H) && bus.req_addr[0])
                   || ((bus.req_size == SZ_W) && (|bus.req_addr[1:0]))
                   || ((bus.req_size == SZ_D) && (|bus.req_addr[2:0]));
  assign err_c     = ((XLEN == 32) && (bus.req_size == SZ_D)) || ((ALIGN_SPLIT == 0) && mis_c);

  // Lane logic sees the live request while idle, the held request afterwards.
  assign sel_off_c  = (state_q == ST_IDLE) ? req_off_c : off_q;
  assign sel_size_c = (state_q == ST_IDLE) ? bus.req_size : ctl_q.size;
  assign rd_lo_c    = (state_q == ST_WAIT1) ? cap_q : bus.mem_rdata;

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .off         (sel_off_c),
    .size        (sel_size_c),
    .uns         (ctl_q.uns),
    .wdata       (bus.req_wdata),
    .rd_lo       (rd_lo_c),
    .rd_hi       (bus.mem_rdata),
    .wdata_rot_c (wrot_c),
    .strb0_c     (strb0_c),
    .strb1_c     (strb1_c),
    .rdata_c     (rfmt_c)
  );

  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    off_d        = off_q;
    split_d      = split_q;
    cap_d        = cap_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ctl_d   = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned};
          off_d   = req_off_c;
          split_d = split_c;
          if (err_c) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d     = ST_REQ0;
            mem_addr_d  = base_c;
            mem_we_d    = bus.req_we;
            mem_wstrb_d = bus.req_we ? strb0_c : '0;
            mem_wdata_d = bus.req_we ? wrot_c : '0;
          end
        end
      end
      ST_REQ0: begin
        if (bus.mem_ready) begin
          if (!ctl_q.we) begin
            state_d = ST_WAIT0;
          end else if (split_q) begin
            state_d     = ST_REQ1;
            mem_addr_d  = mem_addr_q + XLEN'(NB);
            mem_wstrb_d = strb1_c;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT0: begin
        if (bus.mem_rvalid) begin
          if (split_q) begin
            state_d    = ST_REQ1;
            cap_d      = bus.mem_rdata;
            mem_addr_d = mem_addr_q + XLEN'(NB);
          end else begin
            state_d      = ST_RESP;
            resp_rdata_d = rfmt_c;
          end
        end
      end
      ST_REQ1: begin
        if (bus.mem_ready) state_d = ctl_q.we ? ST_RESP : ST_WAIT1;
      end
      ST_WAIT1: begin
        if (bus.mem_rvalid) begin
          state_d      = ST_RESP;
          resp_rdata_d = rfmt_c;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '0;
      off_q        <= '0;
      split_q      <= 1'b0;
      cap_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      off_q        <= off_d;
      split_q      <= split_d;
      cap_q        <= cap_d;
      req_ready_q  <= (state_d == ST_IDLE);
      mem_valid_q  <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= (state_d == ST_RESP);
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/lsu_align_unit.md
# lsu_align_unit

Parametrised multi-cycle load/store unit between the multi-cycle datapath (ALU_Out address register, B register store data) and data memory. It replaces the fixed word-sign-extend/store-select path with full RISC-V size handling: LB/LH/LW/LD in signed and unsigned forms, SB/SH/SW/SD byte strobes, and optional splitting of misaligned accesses into two memory beats. It uses a request/response handshake, so the control FSM can stall on memory wait states.

## Interface
- XLEN, 64: data/address width; 32 or 64 only.
- ALIGN_SPLIT, 1: 1 = misaligned accesses split into two beats; 0 = misaligned accesses flagged as errors.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- mem_valid  out  1  memory beat request.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  XLEN  beat address, aligned to XLEN/8.
- mem_we  out  1  beat is a write.
- mem_wstrb  out  XLEN/8  byte-lane write strobes; all zero on reads.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- resp_valid  out  1  access complete, one-cycle pulse.
- resp_rdata  out  XLEN  formatted load result; 0 for stores and errors.
- resp_err  out  1  access rejected, qualified by resp_valid.

## Operation
- Request fields are registered on acceptance. Let NB = XLEN/8, off = addr mod NB, bytes = 1<<size.
- Error if size==3 with XLEN=32, or if ALIGN_SPLIT=0 and addr is not a multiple of bytes. An error issues no memory beat: IDLE→RESP with resp_err=1.
- Split if off+bytes > NB and ALIGN_SPLIT=1.
  - Beat 0: address addr−off, lanes off..NB−1.
  - Beat 1: address (addr−off+NB) mod 2^XLEN, lanes 0..off+bytes−NB−1.
- Non-split accesses use a single beat: address addr−off, lanes off..off+bytes−1.
- Stores:
  - mem_wdata is req_wdata rotated left by off bytes.
  - Beat 1 carries the remaining upper bytes in the low lanes.
  - mem_wstrb marks exactly the lanes written.
- Loads:
  - Beat bytes are gathered little-endian into a bytes-wide value.
  - The value is sign-extended (req_unsigned=0) or zero-extended to XLEN.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE→REQ0 on accept (or →RESP on error).
  - REQ0→ on mem_ready: loads go to WAIT0; stores go to REQ1 (split) or RESP.
  - WAIT0→ on mem_rvalid: REQ1 (split) or RESP.
  - REQ1/WAIT1 behave the same as REQ0/WAIT0, then go to RESP.
  - RESP→IDLE unconditionally.
- Store beats complete on the mem_valid && mem_ready handshake; no rvalid is expected for stores.

## Timing
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- req_ready = (state==IDLE). mem_valid = state∈{REQ0,REQ1}.
- mem_addr, mem_we, mem_wstrb and mem_wdata are registered and stay stable while mem_valid && !mem_ready.
- mem_rvalid is honoured only in WAIT0/WAIT1 and ignored elsewhere, including IDLE.
- Memory contract: rvalid comes no earlier than the cycle after the beat handshake.
- Latency, counted from the acceptance edge (cycle 0), with zero-wait memory:
  - aligned load: resp_valid in cycle 3;
  - aligned store: cycle 2;
  - error: cycle 1;
  - split load: cycle 5;
  - split store: cycle 3.
- resp_valid lasts exactly one cycle. A new request may be accepted in the cycle after RESP.
- Reset asserted mid-access abandons the access: no resp_valid, mem_valid drops immediately, and late rvalid is ignored.

## Structure
- lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the FSM state enum;
  - a function returning the strobe mask from (off, size, beat).
- Sub-module lsu_lane_align (combinational), used for both directions:
  - store rotate and strobe generation;
  - load gather, combining beat0/beat1 bytes, plus extension.
- The top holds the FSM, the request registers and the beat-0 read capture register.

## Test plan
- XLEN=64, LW at 0x1004, mem_rdata=0x80000001_12345678:
  - signed → resp_rdata=0xFFFFFFFF_80000001;
  - unsigned → resp_rdata=0x00000000_80000001.
- SB at 0x2003 with wdata=0xAB → mem_addr=0x2000, wstrb=0x08, mem_wdata[31:24]=0xAB, resp_valid in cycle 2.
- Split LD at 0x1006:
  - beat0 at 0x1000 returns 0xBBAA0000_00000000;
  - beat1 at 0x1008 returns 0x00006655_44332211;
  - → resp_rdata=0x66554433_2211BBAA, resp_valid in cycle 5.
- ALIGN_SPLIT=0, LH at 0x1001 → mem_valid never asserts; resp_valid with resp_err=1 in cycle 1; resp_rdata=0.
- Split SH at 0xFFFFFFFF_FFFFFFFF with wdata 0x1234:
  - beat0 at 0xFFFFFFFF_FFFFFFF8, wstrb=0x80, lane7=0x34;
  - beat1 at 0x0, wstrb=0x01, lane0=0x12.
- Backpressure and reset:
  - hold mem_ready=0 for 5 cycles → mem_* outputs stay stable;
  - then assert rst in WAIT0 → mem_valid=0 and no resp_valid;
  - an rvalid after reset release has no effect.
